// File: rtl/food_gen.sv
// Food position generator for the snake game: holds the food cell and draws a new
// in-range cell from a free-running LFSR when eaten. Optional macro FOOD_TIMEOUT_EN adds periodic relocation.
//
// state  | meaning
// HOLD   | food committed, waiting for drive (or timeout)
// GEN_X  | rejection-sampling the x candidate from the LFSR
// GEN_Y  | rejection-sampling the y candidate from the LFSR
// COMMIT | publish new cell unless it repeats the current one
module food_gen #(
    parameter int unsigned X_MAX       = 800,
    parameter int unsigned Y_MAX       = 600,
    parameter int unsigned X_INIT      = 200,
    parameter int unsigned Y_INIT      = 150,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       drive,
    input  logic       fin,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic       food_valid,
    output logic [7:0] food_cnt,
    output logic       box_r
);

    typedef enum logic [1:0] {HOLD, GEN_X, GEN_Y, COMMIT} state_t;

    localparam logic [10:0] X_LIM = 11'(X_MAX);
    localparam logic [10:0] Y_LIM = 11'(Y_MAX);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [9:0]  new_x_q, new_x_d;
    logic [9:0]  new_y_q, new_y_d;
    logic [9:0]  box_x_q, box_x_d;
    logic [9:0]  box_y_q, box_y_d;
    logic        valid_q, valid_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [9:0]  cand;

    assign cand = lfsr_q[9:0];

`ifdef FOOD_TIMEOUT_EN
    localparam logic [31:0] TMO_LOAD = TIMEOUT_CYC - 32'd1;
    logic [31:0] tmr_q, tmr_d;

    // Down-counter reloads whenever we are away from HOLD, so it restarts on every entry.
    always_comb begin
        tmr_d = tmr_q;
        if (state_q != HOLD)
            tmr_d = TMO_LOAD;
        else if (!fin && tmr_q != '0)
            tmr_d = tmr_q - 32'd1;
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d = state_q;
        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        new_x_d = new_x_q;
        new_y_d = new_y_q;
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            HOLD: begin
                if (drive && !fin) begin
                    state_d = GEN_X;
                    valid_d = 1'b0;
                    if (cnt_q != 8'hFF)
                        cnt_d = cnt_q + 8'd1;
                end
`ifdef FOOD_TIMEOUT_EN
                else if (!fin && tmr_q == '0) begin
                    state_d = GEN_X;
                    valid_d = 1'b0;
                end
`endif
            end
            GEN_X: begin
                if ({1'b0, cand} < X_LIM) begin
                    new_x_d = cand;
                    state_d = GEN_Y;
                end
            end
            GEN_Y: begin
                if ({1'b0, cand} < Y_LIM) begin
                    new_y_d = cand;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // A repeat of the eaten cell would be matched again by the controller.
                if (new_x_q == box_x_q && new_y_q == box_y_q) begin
                    state_d = GEN_X;
                end else begin
                    box_x_d = new_x_q;
                    box_y_d = new_y_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD;
            lfsr_q  <= SEED;
            new_x_q <= 10'(X_INIT);
            new_y_q <= 10'(Y_INIT);
            box_x_q <= 10'(X_INIT);
            box_y_q <= 10'(Y_INIT);
            valid_q <= 1'b1;
            cnt_q   <= 8'd0;
`ifdef FOOD_TIMEOUT_EN
            tmr_q   <= TMO_LOAD;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            new_x_q <= new_x_d;
            new_y_q <= new_y_d;
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
`ifdef FOOD_TIMEOUT_EN
            tmr_q   <= tmr_d;
`endif
        end
    end

    assign box_x      = box_x_q;
    assign box_y      = box_y_q;
    assign food_valid = valid_q;
    assign food_cnt   = cnt_q;
    assign box_r      = valid_q && (x_pos == box_x_q) && (y_pos == box_y_q);

endmodule

// File: tb/tb_food_gen.sv
// Scoreboard bench for food_gen: stimulus predicts each relocation with an LFSR
// model and queues it; a monitor checks every commit (rising food_valid).
module tb_food_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       drive = 1'b0;
    logic       fin = 1'b0;
    logic [9:0] x_pos = '0;
    logic [9:0] y_pos = '0;
    logic [9:0] box_x, box_y;
    logic       food_valid, box_r;
    logic [7:0] food_cnt;

    food_gen dut (
        .clk(clk), .rst_n(rst_n), .drive(drive), .fin(fin),
        .x_pos(x_pos), .y_pos(y_pos),
        .box_x(box_x), .box_y(box_y), .food_valid(food_valid),
        .food_cnt(food_cnt), .box_r(box_r)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int commits  = 0;
    int extra_lat = 0;

    typedef struct {
        int x;
        int y;
        int cnt;
        int t0;
        int lat;
    } exp_t;
    exp_t q[$];

    int exp_bx  = 200;
    int exp_by  = 150;
    int exp_cnt = 0;

    function automatic logic [15:0] step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= step(m_lfsr);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // l0 is the LFSR value in the cycle drive is sampled; lat counts cycles until the commit is visible.
    task automatic predict(input logic [15:0] l0, input int bx, input int by,
                           output int x, output int y, output int lat);
        logic [15:0] l;
        bit done;
        l = step(l0);
        lat = 1;
        done = 0;
        x = 0;
        y = 0;
        while (!done) begin
            while (l[9:0] >= 10'd800) begin l = step(l); lat++; end
            x = int'(l[9:0]); l = step(l); lat++;
            while (l[9:0] >= 10'd600) begin l = step(l); lat++; end
            y = int'(l[9:0]); l = step(l); lat++;
            if (x == bx && y == by) begin
                l = step(l); lat++;
            end else begin
                lat++;
                done = 1;
            end
        end
    endtask

    // Called at a negedge just before drive is raised for the following posedge.
    task automatic push_expected();
        exp_t e;
        predict(m_lfsr, exp_bx, exp_by, e.x, e.y, e.lat);
        if (exp_cnt < 255) exp_cnt++;
        e.cnt = exp_cnt;
        e.t0  = cyc;
        q.push_back(e);
        exp_bx = e.x;
        exp_by = e.y;
        extra_lat += e.lat - 4;
    endtask

    task automatic pulse_drive();
        drive = 1'b1;
        @(negedge clk);
        drive = 1'b0;
    endtask

    task automatic eat();
        push_expected();
        pulse_drive();
        chk("valid_low_after_drive", food_valid, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("relocation_within_budget", q.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: every rising food_valid must match the head of the queue.
    initial begin
        logic prev_v;
        exp_t e;
        prev_v = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b1;
            end else begin
                if (food_valid && !prev_v) begin
                    commits++;
                    chk("commit_expected", int'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("box_x", box_x, e.x);
                        chk("box_y", box_y, e.y);
                        chk("food_cnt", food_cnt, e.cnt);
                        chk("latency", cyc - e.t0, e.lat);
                        chk("x_in_range", int'(box_x < 10'd800), 1);
                        chk("y_in_range", int'(box_y < 10'd600), 1);
                    end
                end
                prev_v = food_valid;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hx, hy, c0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        chk("reset_box_x", box_x, 200);
        chk("reset_box_y", box_y, 150);
        chk("reset_valid", food_valid, 1);
        chk("reset_cnt", food_cnt, 0);
        x_pos = 10'd200; y_pos = 10'd150; #1;
        chk("box_r_hit", box_r, 1);
        x_pos = 10'd201; #1;
        chk("box_r_miss", box_r, 0);
        @(negedge clk);

        // single meal
        eat();
        wait_idle();
        chk("cnt_after_one", food_cnt, 1);
        chk("moved_from_init", int'(box_x != 10'd200 || box_y != 10'd150), 1);
        x_pos = 10'(exp_bx); y_pos = 10'(exp_by); #1;
        chk("box_r_new_pos", box_r, 1);
        @(negedge clk);

        // controller re-pulses every other cycle while the head sits on the stale box
        hx = exp_bx; hy = exp_by; c0 = commits;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0 && int'(box_x) == hx && int'(box_y) == hy) begin
                if (i == 0) push_expected();
                drive = 1'b1;
            end
            @(negedge clk);
            drive = 1'b0;
            if (i == 0) chk("valid_low_chase", food_valid, 0);
        end
        wait_idle();
        chk("chase_one_relocation", commits - c0, 1);
        chk("chase_cnt", food_cnt, 2);

        // fin freezes the block
        fin = 1'b1; c0 = commits;
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            drive = (i % 7 == 0);
            @(negedge clk);
        end
        drive = 1'b0;
        chk("fin_box_x", box_x, exp_bx);
        chk("fin_box_y", box_y, exp_by);
        chk("fin_cnt", food_cnt, exp_cnt);
        chk("fin_no_commit", commits - c0, 0);
        chk("fin_valid", food_valid, 1);
        fin = 1'b0;
        @(negedge clk);

        // fin mid-generation: draw completes, then block freezes
        eat();
        fin = 1'b1;
        wait_idle();
        c0 = commits;
        repeat (5) begin
            pulse_drive();
            @(negedge clk);
        end
        chk("fin_mid_cnt", food_cnt, exp_cnt);
        chk("fin_mid_no_commit", commits - c0, 0);
        fin = 1'b0;
        @(negedge clk);

        // async reset in the middle of a draw
        pulse_drive();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_box_x", box_x, 200);
        chk("rst_mid_box_y", box_y, 150);
        chk("rst_mid_valid", food_valid, 1);
        chk("rst_mid_cnt", food_cnt, 0);
        q.delete();
        exp_bx = 200; exp_by = 150; exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // many meals: saturation and rejection retries
        extra_lat = 0;
        for (int i = 0; i < 300; i++) begin
            eat();
            wait_idle();
        end
        chk("cnt_saturated", food_cnt, 255);
        chk("retry_cycles_seen", int'(extra_lat > 0), 1);
        chk("final_valid", food_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/food_gen.md
# food_gen

Food generator for the snake game, sitting directly upstream of the snake controller. It holds the current food cell (`box_x`, `box_y`) that the controller compares against the snake head. When the controller's one-cycle `drive` pulse reports the food eaten, this block draws a new in-range position from a free-running LFSR and counts the meal. It also produces the per-pixel food render bit for the VGA mixer.

## Interface
Parameters:
- `X_MAX`, 800: exclusive upper bound of the x coordinate.
- `Y_MAX`, 600: exclusive upper bound of the y coordinate.
- `X_INIT`, 200: food x after reset.
- `Y_INIT`, 150: food y after reset.
- `SEED`, 16'hACE1: LFSR reset value. Must be nonzero.
- `TIMEOUT_CYC`, 32'd500_000_000: relocation period. Used only with `FOOD_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `drive`, in, 1: one-cycle pulse from the snake controller meaning the head is on the food.
- `fin`, in, 1: game-over level. Freezes the block.
- `x_pos`, in, 10: current scan pixel x.
- `y_pos`, in, 10: current scan pixel y.
- `box_x`, out, 10: food x coordinate. Registered.
- `box_y`, out, 10: food y coordinate. Registered.
- `food_valid`, out, 1: high while `box_x`/`box_y` hold a committed position.
- `food_cnt`, out, 8: foods eaten. Saturates at 255.
- `box_r`, out, 1: food pixel render bit. Combinational.

## Operation
- LFSR:
  - 16-bit Galois, taps 16'hB400.
  - Each step: `lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0)`.
  - Advances every cycle, including during `fin`.
  - Reset value is `SEED`.
  - The candidate value is `lfsr[9:0]`.
- FSM states: HOLD, GEN_X, GEN_Y, COMMIT. Reset state is HOLD.
- HOLD:
  - `drive && !fin` → GEN_X.
  - On the same edge: `food_valid <= 0`, and `food_cnt <= food_cnt + 1` unless it is already 255.
  - `fin` high → stay in HOLD and ignore `drive`.
- GEN_X:
  - If candidate < `X_MAX`: latch it into `new_x`, go to GEN_Y.
  - Otherwise stay in GEN_X and retry next cycle (rejection sampling).
- GEN_Y:
  - If candidate < `Y_MAX`: latch it into `new_y`, go to COMMIT.
  - Otherwise retry next cycle.
- COMMIT:
  - If (`new_x`, `new_y`) equals the current (`box_x`, `box_y`), return to GEN_X. This keeps the controller from matching the stale cell again.
  - Otherwise load `box_x <= new_x`, `box_y <= new_y`, set `food_valid <= 1`, go to HOLD.
- `drive` in any state other than HOLD is ignored. The controller re-pulses `drive` every other cycle while the head sits on the stale box, so these pulses must be dropped.
- `fin` asserted mid-generation: the FSM completes its draw to HOLD, then freezes there.
- `box_x`/`box_y` keep the old position until COMMIT; they never carry an out-of-range value.
- `box_r = food_valid && x_pos == box_x && y_pos == box_y`.
- Reset values: `box_x = X_INIT`, `box_y = Y_INIT`, `food_valid = 1`, `food_cnt = 0`, state HOLD, `lfsr = SEED`.

## Timing
- `drive` sampled high in HOLD at cycle N:
  - `food_valid = 0` and `food_cnt` incremented, visible in cycle N+1.
  - Minimum relocation latency is 4 cycles: new `box_x`/`box_y` and `food_valid = 1` visible in cycle N+4.
- Each rejected candidate or rejected duplicate adds 1 or 3 cycles respectively.
- Termination is guaranteed by the maximal-length LFSR.
- `box_r` has zero latency with respect to `x_pos`/`y_pos`.
- Reset is asynchronous: asserting `rst_n` mid-generation returns all outputs to their reset values immediately, with no partial commit.

## Configuration
- Macro: `FOOD_TIMEOUT_EN`.
- Defined:
  - A 32-bit counter runs while in HOLD with `!fin`.
  - It clears on entry to HOLD and holds its value while `fin` is high.
  - When it reaches `TIMEOUT_CYC - 1`, the FSM goes to GEN_X exactly as for `drive`, except `food_cnt` is not incremented.
  - If `drive` and the timeout coincide, `drive` wins and the count increments.
- Undefined: no counter exists, and food moves only on `drive`.

## Test plan
- Reset, then idle 10 cycles → `box_x = 200`, `box_y = 150`, `food_valid = 1`, `food_cnt = 0`. With `x_pos = 200`, `y_pos = 150` → `box_r = 1`; with `x_pos = 201` → `box_r = 0`.
- Single `drive` pulse at cycle N → `food_valid = 0` at N+1. New position appears at N+4 or later, matches a cycle-accurate LFSR model, satisfies `box_x < 800` and `box_y < 600`, differs from (200,150), and `food_cnt = 1`.
- `drive` pulsed every other cycle for 20 cycles starting at N → exactly one relocation and `food_cnt = 1`.
- `fin = 1` then `drive` pulses → `box_x`, `box_y`, and `food_cnt` are unchanged for 1000 cycles.
- 300 relocations → `food_cnt` saturates at 255; every committed position is in range; LFSR rejections are observed as retry cycles.
- With `FOOD_TIMEOUT_EN` and `TIMEOUT_CYC = 100`, no `drive` → relocation starts at HOLD cycle 100 and `food_cnt` stays 0. With `drive` in the same cycle as the timeout → `food_cnt = 1`.
